audio_in: RTL and testbench



---
 rtl/audio_in.sv | 98 +++++++++
 tb/tb_audio_in.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/audio_in.sv
// Stereo first-order sigma-delta ADC back end: comparator sync, 1-bit feedback,
// sinc1 decimation to 8-bit unsigned samples and a one-deep valid/ready holding stage.
module audio_in #(
    parameter int DECIM_LOG2  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_pwm,
    input  logic       rst,
    input  logic       cmp_left,
    input  logic       cmp_right,
    output logic       fb_left,
    output logic       fb_right,
    output logic [7:0] data_left,
    output logic [7:0] data_right,
    output logic       valid,
    input  logic       ready,
    input  logic       overrun_clr,
    output logic       overrun
);

    localparam int SH = DECIM_LOG2 - 8;
    localparam logic [DECIM_LOG2-1:0] WMAX = '1;

    logic [SYNC_STAGES-1:0] sync_l;
    logic [SYNC_STAGES-1:0] sync_r;
    logic [DECIM_LOG2-1:0]  win_cnt;
    logic [DECIM_LOG2:0]    acc_l;
    logic [DECIM_LOG2:0]    acc_r;
    logic [DECIM_LOG2:0]    sum_l;
    logic [DECIM_LOG2:0]    sum_r;
    logic                   win_end;
    logic                   accept;

    // A full window of ones (sum == W) only fits in 9 bits, so it saturates.
    function automatic logic [7:0] scale(input logic [DECIM_LOG2:0] sum);
        scale = sum[DECIM_LOG2] ? 8'hFF : sum[SH +: 8];
    endfunction

    assign sum_l   = acc_l + {{DECIM_LOG2{1'b0}}, fb_left};
    assign sum_r   = acc_r + {{DECIM_LOG2{1'b0}}, fb_right};
    assign win_end = (win_cnt == WMAX);
    assign accept  = !valid || ready;

    always_ff @(posedge clk_pwm) begin
        if (rst) begin
            sync_l   <= '0;
            sync_r   <= '0;
            fb_left  <= 1'b0;
            fb_right <= 1'b0;
        end else begin
            sync_l   <= {sync_l[SYNC_STAGES-2:0], cmp_left};
            sync_r   <= {sync_r[SYNC_STAGES-2:0], cmp_right};
            fb_left  <= sync_l[SYNC_STAGES-1];
            fb_right <= sync_r[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk_pwm) begin
        if (rst) begin
            win_cnt <= '0;
            acc_l   <= '0;
            acc_r   <= '0;
        end else begin
            win_cnt <= win_cnt + 1'b1;
            if (win_end) begin
                acc_l <= '0;
                acc_r <= '0;
            end else begin
                acc_l <= sum_l;
                acc_r <= sum_r;
            end
        end
    end

    always_ff @(posedge clk_pwm) begin
        if (rst) begin
            data_left  <= 8'h00;
            data_right <= 8'h00;
            valid      <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (win_end && accept) begin
                data_left  <= scale(sum_l);
                data_right <= scale(sum_r);
                valid      <= 1'b1;
            end else if (!win_end && valid && ready) begin
                valid <= 1'b0;
            end
            // A dropped pair outranks a simultaneous clear.
            if (win_end && !accept) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_audio_in.sv
// Directed bench for audio_in: scoreboard of expected sample pairs,
// popped and compared whenever the DUT presents valid data.
module tb_audio_in;

    logic       clk_pwm = 1'b0;
    logic       rst, cmp_left, cmp_right, ready, overrun_clr;
    logic       fb_left, fb_right, valid, overrun;
    logic [7:0] data_left, data_right;

    logic       rst10, cmp10, ready10, clr10;
    logic       fbl10, fbr10, valid10, ovr10;
    logic [7:0] dl10, dr10;

    int pass_cnt = 0;
    int total    = 0;
    logic [15:0] exp_q[$];
    bit   mode = 1'b0;
    int   ph   = 0;

    always #5 clk_pwm = ~clk_pwm;

    audio_in #(.DECIM_LOG2(8), .SYNC_STAGES(2)) dut (
        .clk_pwm(clk_pwm), .rst(rst),
        .cmp_left(cmp_left), .cmp_right(cmp_right),
        .fb_left(fb_left), .fb_right(fb_right),
        .data_left(data_left), .data_right(data_right),
        .valid(valid), .ready(ready),
        .overrun_clr(overrun_clr), .overrun(overrun)
    );

    audio_in #(.DECIM_LOG2(10), .SYNC_STAGES(2)) dut10 (
        .clk_pwm(clk_pwm), .rst(rst10),
        .cmp_left(cmp10), .cmp_right(cmp10),
        .fb_left(fbl10), .fb_right(fbr10),
        .data_left(dl10), .data_right(dr10),
        .valid(valid10), .ready(ready10),
        .overrun_clr(clr10), .overrun(ovr10)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_pwm);
            #1;
            if (mode) begin
                cmp_left  = ~cmp_left;
                cmp_right = (ph == 0);
                ph        = (ph + 1) % 4;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic pop_chk(input string tag);
        logic [15:0] e;
        if (exp_q.size() == 0) begin
            chk({tag, "_q_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_l"}, {24'd0, data_left},  {24'd0, e[15:8]});
            chk({tag, "_r"}, {24'd0, data_right}, {24'd0, e[7:0]});
        end
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n = 0;
        while (!valid && n < budget) begin
            step(1);
            n++;
        end
        chk({tag, "_valid"}, {31'd0, valid}, 32'd1);
    endtask

    task automatic do_reset(input logic l, input logic r);
        rst       = 1'b1;
        cmp_left  = l;
        cmp_right = r;
        step(2);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cmp_left = 1'b0; cmp_right = 1'b0;
        ready = 1'b0; overrun_clr = 1'b0;
        rst10 = 1'b1; cmp10 = 1'b1; ready10 = 1'b1; clr10 = 1'b0;
        step(2);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_data", {16'd0, data_left, data_right}, 32'd0);
        chk("rst_fb", {30'd0, fb_left, fb_right}, 32'd0);
        rst10 = 1'b0;

        // constant 1: first window misses three latency cycles
        do_reset(1'b1, 1'b1);
        step(2);
        chk("t1_fb_e2", {30'd0, fb_left, fb_right}, 32'd0);
        step(1);
        chk("t1_fb_e3", {30'd0, fb_left, fb_right}, 32'd3);
        step(252);
        chk("t1_e255_valid", {31'd0, valid}, 32'd0);
        exp_q.push_back(16'hFDFD);
        step(1);
        chk("t1_e256_valid", {31'd0, valid}, 32'd1);
        pop_chk("t1_w1");
        ready = 1'b1;
        step(1);
        chk("t1_consumed", {31'd0, valid}, 32'd0);
        exp_q.push_back(16'hFFFF);
        step(255);
        chk("t1_e512_valid", {31'd0, valid}, 32'd1);
        pop_chk("t1_w2");
        chk("t1_ovr", {31'd0, overrun}, 32'd0);

        // constant 0
        do_reset(1'b0, 1'b0);
        ready = 1'b1;
        for (int w = 0; w < 2; w++) begin
            exp_q.push_back(16'h0000);
            wait_valid("t2", 300);
            pop_chk("t2_w");
            step(1);
        end
        chk("t2_fb", {30'd0, fb_left, fb_right}, 32'd0);
        chk("t2_ovr", {31'd0, overrun}, 32'd0);

        // periodic patterns: half density left, quarter density right
        do_reset(1'b0, 1'b0);
        ph = 0;
        mode = 1'b1;
        wait_valid("t3_first", 300);
        step(1);
        for (int w = 0; w < 2; w++) begin
            exp_q.push_back(16'h8040);
            wait_valid("t3", 300);
            pop_chk("t3_w");
            step(1);
        end
        mode = 1'b0;

        // backpressure across two window ends
        do_reset(1'b1, 1'b1);
        ready = 1'b0;
        exp_q.push_back(16'hFDFD);
        wait_valid("t4", 300);
        pop_chk("t4_w1");
        step(255);
        chk("t4_ovr_pre", {31'd0, overrun}, 32'd0);
        exp_q.push_back(16'hFDFD);
        step(1);
        chk("t4_ovr_set", {31'd0, overrun}, 32'd1);
        chk("t4_held_valid", {31'd0, valid}, 32'd1);
        pop_chk("t4_held");
        ready = 1'b1;
        step(1);
        ready = 1'b0;
        chk("t4_drain", {31'd0, valid}, 32'd0);
        chk("t4_ovr_sticky", {31'd0, overrun}, 32'd1);
        overrun_clr = 1'b1;
        step(1);
        overrun_clr = 1'b0;
        chk("t4_ovr_clr", {31'd0, overrun}, 32'd0);

        // ready coincident with window end while valid is held
        exp_q.push_back(16'hFFFF);
        wait_valid("t5", 300);
        cmp_right = 1'b0;
        pop_chk("t5_w1");
        step(255);
        chk("t5_hold", {31'd0, valid}, 32'd1);
        ready = 1'b1;
        exp_q.push_back(16'hFF03);
        step(1);
        chk("t5_valid", {31'd0, valid}, 32'd1);
        chk("t5_ovr", {31'd0, overrun}, 32'd0);
        pop_chk("t5_new");

        // reset in the middle of a window
        step(99);
        rst = 1'b1;
        step(1);
        chk("t6_valid", {31'd0, valid}, 32'd0);
        chk("t6_data", {16'd0, data_left, data_right}, 32'd0);
        chk("t6_fb_ovr", {29'd0, fb_left, fb_right, overrun}, 32'd0);
        rst = 1'b0;
        cmp_left = 1'b1;
        cmp_right = 1'b1;
        step(255);
        chk("t6_e255", {31'd0, valid}, 32'd0);
        exp_q.push_back(16'hFDFD);
        step(1);
        chk("t6_e256", {31'd0, valid}, 32'd1);
        pop_chk("t6_w");

        // wide window instance has run with cmp=1 since the start
        chk("t7_total_edges", {31'd0, (total > 0)}, 32'd1);
        chk("t7_data10", {16'd0, dl10, dr10}, 32'h0000FFFF);
        chk("t7_ovr10", {31'd0, ovr10}, 32'd0);
        chk("sb_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
